// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the pipeline WB stage (priority) and a
// FIFO-buffered auxiliary requester. It exports a pending-register mask and a starvation stall.
module regfile_wb_arbiter #(
  parameter int AUX_DEPTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  input  logic        aux_valid,
  input  logic [3:0]  aux_dest,
  input  logic [31:0] aux_value,
  output logic        aux_ready,
  output logic        WriteBackEn,
  output logic [3:0]  Dest_wb,
  output logic [31:0] Result_WB,
  output logic [14:0] pending_mask,
  output logic        stall_req,
  output logic        aux_drop
);

  localparam int         DATA_W = 32;
  localparam int         PTR_W  = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;
  localparam int         CNT_W  = PTR_W + 1;
  localparam int         STV_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [3:0] NO_REG = 4'hF;

  function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
    if (v >= STV_W'(STARVE_LIMIT))
      return STV_W'(STARVE_LIMIT);
    return v + STV_W'(1);
  endfunction

  // Register 15 does not exist, so it maps to an empty mask.
  function automatic logic [14:0] reg_onehot(input logic [3:0] d);
    return 15'(1) << d;
  endfunction

  logic [3:0]        dest_mem [AUX_DEPTH];
  logic [DATA_W-1:0] data_mem [AUX_DEPTH];
  logic [AUX_DEPTH-1:0] slot_vld;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve_cnt;
  logic [STV_W-1:0]  starve_nxt;

  logic wb_req;
  logic fifo_empty;
  logic fifo_full;
  logic aux_hs;
  logic push;
  logic pop;

  always_comb begin
    wb_req     = wb_en && (wb_dest != NO_REG) && !rst;
    fifo_empty = (count == '0);
    fifo_full  = (count == CNT_W'(AUX_DEPTH));
    aux_ready  = !fifo_full;
    aux_hs     = aux_valid && !fifo_full;
    push       = aux_hs && (aux_dest != NO_REG);
    pop        = !wb_req && !fifo_empty;
  end

  // Write-port select: WB wins; otherwise the FIFO head uses the idle slot.
  always_comb begin
    WriteBackEn = 1'b0;
    Dest_wb     = '0;
    Result_WB   = '0;
    if (wb_req) begin
      WriteBackEn = 1'b1;
      Dest_wb     = wb_dest;
      Result_WB   = wb_value;
    end else if (!fifo_empty) begin
      WriteBackEn = 1'b1;
      Dest_wb     = dest_mem[rd_ptr];
      Result_WB   = data_mem[rd_ptr];
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < AUX_DEPTH; i++) begin
      if (slot_vld[i])
        pending_mask = pending_mask | reg_onehot(dest_mem[i]);
    end
  end

  always_comb begin
    if (fifo_empty || pop)
      starve_nxt = '0;
    else
      starve_nxt = sat_inc(starve_cnt);
  end

  // Payload storage carries no reset; slot_vld alone qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr] <= aux_dest;
      data_mem[wr_ptr] <= aux_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      slot_vld <= '0;
    end else begin
      if (push) begin
        wr_ptr           <= wr_ptr + PTR_W'(1);
        slot_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr           <= rd_ptr + PTR_W'(1);
        slot_vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Starvation counter and the registered stall/drop indications.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
      aux_drop   <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      stall_req  <= (starve_nxt == STV_W'(STARVE_LIMIT));
      aux_drop   <= aux_hs && (aux_dest == NO_REG);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, WB priority, aux draining, back-pressure,
// starvation stall and dest-15 drops, with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        aux_valid;
  logic [3:0]  aux_dest;
  logic [31:0] aux_value;
  logic        aux_ready;
  logic        WriteBackEn;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;
  logic [14:0] pending_mask;
  logic        stall_req;
  logic        aux_drop;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.AUX_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .aux_valid(aux_valid), .aux_dest(aux_dest), .aux_value(aux_value),
    .aux_ready(aux_ready),
    .WriteBackEn(WriteBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
    .pending_mask(pending_mask), .stall_req(stall_req), .aux_drop(aux_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_aux(input logic [3:0] d, input logic [31:0] v);
    aux_valid = 1'b1;
    aux_dest  = d;
    aux_value = v;
    tick();
    aux_valid = 1'b0;
  endtask

  task automatic chk_port(input string tag, input logic en, input logic [3:0] d, input logic [31:0] v);
    chk({tag, "_en"},   32'(WriteBackEn), 32'(en));
    chk({tag, "_dest"}, 32'(Dest_wb),     32'(d));
    chk({tag, "_data"}, Result_WB,        v);
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b0; wb_dest = '0; wb_value = '0;
    aux_valid = 1'b0; aux_dest = '0; aux_value = '0;
    repeat (2) tick();
    chk("rst_ready", 32'(aux_ready),   32'd1);
    chk("rst_wben",  32'(WriteBackEn), 32'd0);
    chk("rst_mask",  32'(pending_mask), 32'd0);
    chk("rst_stall", 32'(stall_req),   32'd0);
    chk("rst_drop",  32'(aux_drop),    32'd0);
    rst = 1'b0;
    tick();

    // WB only
    wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hDEAD0003;
    #1 chk_port("wb3", 1'b1, 4'd3, 32'hDEAD0003);
    wb_dest = 4'd15;
    #1 chk_port("wb15", 1'b0, 4'd0, 32'h0);
    wb_en = 1'b0;
    tick();

    // Aux in idle slot
    push_aux(4'd5, 32'h55);
    chk_port("aux5", 1'b1, 4'd5, 32'h55);
    chk("aux5_mask", 32'(pending_mask), 32'h20);
    tick();
    chk("aux5_mask_clr", 32'(pending_mask), 32'h0);
    chk("aux5_idle",     32'(WriteBackEn),  32'd0);

    // Full / back-pressure with WB busy
    wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h77;
    push_aux(4'd1, 32'hA1);
    push_aux(4'd2, 32'hA2);
    push_aux(4'd1, 32'hA3);
    chk("full_ready3", 32'(aux_ready), 32'd1);
    push_aux(4'd4, 32'hA4);
    chk("full_ready", 32'(aux_ready), 32'd0);
    chk("full_mask",  32'(pending_mask), 32'h16);
    chk_port("full_wbprio", 1'b1, 4'd7, 32'h77);
    wb_en = 1'b0;
    #1 chk_port("drain0", 1'b1, 4'd1, 32'hA1);
    chk("drain0_ready", 32'(aux_ready), 32'd0);
    tick();
    chk_port("drain1", 1'b1, 4'd2, 32'hA2);
    chk("drain1_mask",  32'(pending_mask), 32'h16);
    chk("drain1_ready", 32'(aux_ready), 32'd1);
    tick();
    chk_port("drain2", 1'b1, 4'd1, 32'hA3);
    chk("drain2_mask", 32'(pending_mask), 32'h12);
    tick();
    chk_port("drain3", 1'b1, 4'd4, 32'hA4);
    chk("drain3_mask", 32'(pending_mask), 32'h10);
    tick();
    chk("drain_done_en",   32'(WriteBackEn),  32'd0);
    chk("drain_done_mask", 32'(pending_mask), 32'h0);
    chk("drain_stall",     32'(stall_req),    32'd0);

    // Starvation guard
    wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h77;
    push_aux(4'd9, 32'h99);
    repeat (7) tick();
    chk("starve_7", 32'(stall_req), 32'd0);
    tick();
    chk("starve_8", 32'(stall_req), 32'd1);
    repeat (2) tick();
    chk("starve_hold", 32'(stall_req), 32'd1);
    wb_en = 1'b0;
    #1 chk_port("starve_pop", 1'b1, 4'd9, 32'h99);
    chk("starve_pop_stall", 32'(stall_req), 32'd1);
    tick();
    chk("starve_release", 32'(stall_req),    32'd0);
    chk("starve_empty",   32'(WriteBackEn),  32'd0);
    chk("starve_mask",    32'(pending_mask), 32'h0);

    // Dest 15 aux request
    chk("d15_ready", 32'(aux_ready), 32'd1);
    push_aux(4'd15, 32'hFF);
    chk("d15_drop", 32'(aux_drop),     32'd1);
    chk("d15_mask", 32'(pending_mask), 32'h0);
    chk("d15_en",   32'(WriteBackEn),  32'd0);
    tick();
    chk("d15_drop_end", 32'(aux_drop),    32'd0);
    chk("d15_en2",      32'(WriteBackEn), 32'd0);

    // Reset mid-stream with three queued entries
    wb_en = 1'b1; wb_dest = 4'd7; wb_value = 32'h77;
    push_aux(4'd3, 32'hC3);
    push_aux(4'd6, 32'hC6);
    push_aux(4'd8, 32'hC8);
    chk("mid_mask", 32'(pending_mask), 32'h148);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(aux_ready),    32'd1);
    chk("mid_rst_mask",  32'(pending_mask), 32'h0);
    chk("mid_rst_wben",  32'(WriteBackEn),  32'd0);
    chk("mid_rst_stall", 32'(stall_req),    32'd0);
    tick();
    rst = 1'b0; wb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("mid_no_stale", 32'(WriteBackEn), 32'd0);
      tick();
    end
    chk("mid_final_mask", 32'(pending_mask), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
